// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct field values, ALU control codes and the control-word bundle.
// Also consumed by the ALU and its bench for the ALUctl codes.
package mc_control_unit_pkg;

  // State encoding (13 used of 16; the rest recover to FETCH)
  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMRD    = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWR    = 4'd5;
  localparam logic [3:0] ST_RTYPE_EX = 4'd6;
  localparam logic [3:0] ST_RTYPE_WB = 4'd7;
  localparam logic [3:0] ST_BEQ_EX   = 4'd8;
  localparam logic [3:0] ST_ADDI_EX  = 4'd9;
  localparam logic [3:0] ST_ADDI_WB  = 4'd10;
  localparam logic [3:0] ST_JUMP     = 4'd11;
  localparam logic [3:0] ST_TRAP     = 4'd12;

  typedef enum logic [3:0] {
    S_FETCH    = ST_FETCH,
    S_DECODE   = ST_DECODE,
    S_MEMADR   = ST_MEMADR,
    S_MEMRD    = ST_MEMRD,
    S_MEMWB    = ST_MEMWB,
    S_MEMWR    = ST_MEMWR,
    S_RTYPE_EX = ST_RTYPE_EX,
    S_RTYPE_WB = ST_RTYPE_WB,
    S_BEQ_EX   = ST_BEQ_EX,
    S_ADDI_EX  = ST_ADDI_EX,
    S_ADDI_WB  = ST_ADDI_WB,
    S_JUMP     = ST_JUMP,
    S_TRAP     = ST_TRAP
  } state_t;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUctl codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Moore part of the control word (pc_en / ir_write are handled separately)
  typedef struct packed {
    logic [3:0] alu_ctl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] pc_source;
  } ctl_t;

  // States whose exit to FETCH completes an instruction
  function automatic logic is_final(input state_t s);
    return (s == S_MEMWB)    || (s == S_MEMWR)   || (s == S_RTYPE_WB) ||
           (s == S_BEQ_EX)   || (s == S_ADDI_WB) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/mc_control_unit_alu_ctl_decode.sv
// Purpose: R-type funct -> 4-bit ALUctl, plus a flag for supported functs.
// Latency: combinational. Backpressure: none.
// Ports: funct (in, 6) ; alu_ctl (out, 4, ADD when unsupported) ; legal (out, 1).
module mc_control_unit_alu_ctl_decode
  import mc_control_unit_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_ctl,
  output logic       legal
);

  always_comb begin
    alu_ctl = ALU_ADD;
    legal   = 1'b1;
    case (funct)
      FN_ADD:  alu_ctl = ALU_ADD;
      FN_SUB:  alu_ctl = ALU_SUB;
      FN_AND:  alu_ctl = ALU_AND;
      FN_OR:   alu_ctl = ALU_OR;
      FN_SLT:  alu_ctl = ALU_SLT;
      default: legal   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Purpose: multicycle MIPS control FSM driving ALU control and datapath muxes/enables.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles with mem_ready held high.
// Backpressure: FETCH, MEMRD and MEMWR hold until mem_ready; TRAP holds until reset.
// Ports: clk, rst_n (sync, active-low); op, funct from IR; zero from ALU;
//   mem_ready handshake; datapath controls alu_ctl..pc_en; illegal (sticky);
//   instr_count (retired, wraps); state_dbg (current state encoding).
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       alu_ctl,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       pc_source,
  output logic             pc_en,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nxt;
  ctl_t       ctl_q;
  logic [3:0] rt_alu_ctl;
  logic       funct_legal;
  logic       retire;

  mc_control_unit_alu_ctl_decode u_alu_ctl_decode (
    .funct   (funct),
    .alu_ctl (rt_alu_ctl),
    .legal   (funct_legal)
  );

  // Control word for a given state. Evaluated on the next state so the
  // Moore outputs come straight from flops yet line up with state.
  function automatic ctl_t moore_ctl(input state_t s, input logic [3:0] rt_ctl);
    ctl_t c;
    c = '0;
    c.alu_ctl = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_ctl   = rt_ctl;
      end
      S_RTYPE_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BEQ_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_ctl   = ALU_SUB;
        c.pc_source = 2'b01;
      end
      S_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB:  c.reg_write = 1'b1;
      S_JUMP:     c.pc_source = 2'b10;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = funct_legal ? S_RTYPE_EX : S_TRAP;
          OP_BEQ:       state_nxt = S_BEQ_EX;
          OP_ADDI:      state_nxt = S_ADDI_EX;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWR:    state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: state_nxt = S_RTYPE_WB;
      S_RTYPE_WB: state_nxt = S_FETCH;
      S_BEQ_EX:   state_nxt = S_FETCH;
      S_ADDI_EX:  state_nxt = S_ADDI_WB;
      S_ADDI_WB:  state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;  // unused encodings recover without retiring
    endcase
  end

  assign retire = (state_nxt == S_FETCH) && is_final(state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      ctl_q       <= moore_ctl(S_FETCH, ALU_ADD);
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      ctl_q <= moore_ctl(state_nxt, rt_alu_ctl);
      if (state_nxt == S_TRAP)
        illegal <= 1'b1;
      if (retire)
        instr_count <= instr_count + CNT_ONE;
    end
  end

  assign alu_ctl    = ctl_q.alu_ctl;
  assign alu_src_a  = ctl_q.alu_src_a;
  assign alu_src_b  = ctl_q.alu_src_b;
  assign mem_read   = ctl_q.mem_read;
  assign mem_write  = ctl_q.mem_write;
  assign iord       = ctl_q.iord;
  assign reg_dst    = ctl_q.reg_dst;
  assign mem_to_reg = ctl_q.mem_to_reg;
  assign reg_write  = ctl_q.reg_write;
  assign pc_source  = ctl_q.pc_source;

  // The two handshake-qualified enables: PC+4 / IR load when the fetch
  // completes, conditional branch on zero, unconditional jump.
  assign ir_write = (state == S_FETCH) && mem_ready;
  assign pc_en    = ((state == S_FETCH)  && mem_ready) ||
                    ((state == S_BEQ_EX) && zero)      ||
                     (state == S_JUMP);

  assign state_dbg = state;

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic [3:0] alu_ctl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
  logic [1:0] pc_source;
  logic       pc_en, illegal;
  logic [3:0] instr_count;
  logic [3:0] state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_ctl(alu_ctl), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .pc_source(pc_source), .pc_en(pc_en),
    .illegal(illegal), .instr_count(instr_count), .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instruction class is a fixed list of phases; the model walks that
  // list, waiting in memory phases while mem_ready is low.
  int m_pos = 0;
  int m_cnt = 0;
  bit m_on  = 1'b0;

  function automatic bit legal_fn(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic int seq_len(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return legal_fn(f) ? 4 : 3;
      6'b001000: return 4;
      default:   return 3;
    endcase
  endfunction

  function automatic logic [3:0] seq_phase(input logic [5:0] o, input logic [5:0] f, input int pos);
    if (pos == 0) return ST_FETCH;
    if (pos == 1) return ST_DECODE;
    case (o)
      6'b100011: return (pos == 2) ? ST_MEMADR : (pos == 3) ? ST_MEMRD : ST_MEMWB;
      6'b101011: return (pos == 2) ? ST_MEMADR : ST_MEMWR;
      6'b000000: return !legal_fn(f) ? ST_TRAP : (pos == 2) ? ST_RTYPE_EX : ST_RTYPE_WB;
      6'b000100: return ST_BEQ_EX;
      6'b001000: return (pos == 2) ? ST_ADDI_EX : ST_ADDI_WB;
      6'b000010: return ST_JUMP;
      default:   return ST_TRAP;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // {alu_ctl, src_a, src_b, mem_read, mem_write, iord, ir_write,
  //  reg_dst, mem_to_reg, reg_write, pc_source, pc_en}
  function automatic logic [16:0] exp_ctl(input logic [3:0] ph, input logic [5:0] f,
                                          input logic z, input logic mr);
    logic [3:0] a;  logic sa;  logic [1:0] sb;  logic rd_s, wr_s, io, irw;
    logic rdst, m2r, rw;  logic [1:0] ps;  logic pe;
    a = 4'b0010; sa = 0; sb = 2'b00; rd_s = 0; wr_s = 0; io = 0; irw = 0;
    rdst = 0; m2r = 0; rw = 0; ps = 2'b00; pe = 0;
    case (ph)
      ST_FETCH:    begin rd_s = 1; sb = 2'b01; irw = mr; pe = mr; end
      ST_DECODE:   sb = 2'b11;
      ST_MEMADR:   begin sa = 1; sb = 2'b10; end
      ST_MEMRD:    begin rd_s = 1; io = 1; end
      ST_MEMWB:    begin m2r = 1; rw = 1; end
      ST_MEMWR:    begin wr_s = 1; io = 1; end
      ST_RTYPE_EX: begin sa = 1; a = r_alu(f); end
      ST_RTYPE_WB: begin rdst = 1; rw = 1; end
      ST_BEQ_EX:   begin sa = 1; a = 4'b0110; ps = 2'b01; pe = z; end
      ST_ADDI_EX:  begin sa = 1; sb = 2'b10; end
      ST_ADDI_WB:  rw = 1;
      ST_JUMP:     begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {a, sa, sb, rd_s, wr_s, io, irw, rdst, m2r, rw, ps, pe};
  endfunction

  logic [16:0] dut_ctl;
  assign dut_ctl = {alu_ctl, alu_src_a, alu_src_b, mem_read, mem_write, iord, ir_write,
                    reg_dst, mem_to_reg, reg_write, pc_source, pc_en};

  always @(posedge clk) begin : model_step
    logic [3:0] ph;
    if (!rst_n) begin
      m_pos = 0; m_cnt = 0; m_on = 1'b1;
    end else if (m_on) begin
      ph = seq_phase(op, funct, m_pos);
      if (ph == ST_TRAP) begin
      end else if ((ph == ST_FETCH || ph == ST_MEMRD || ph == ST_MEMWR) && !mem_ready) begin
      end else if (m_pos == seq_len(op, funct) - 1) begin
        m_pos = 0;
        m_cnt = (m_cnt + 1) % 16;
      end else begin
        m_pos = m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] ph;
    if (m_on) begin
      ph = seq_phase(op, funct, m_pos);
      chk("state",   32'(state_dbg),   32'(ph));
      chk("ctl",     32'(dut_ctl),     32'(exp_ctl(ph, funct, zero, mem_ready)));
      chk("count",   32'(instr_count), m_cnt);
      chk("illegal", 32'(illegal),     32'(ph == ST_TRAP));
      chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
      chk("rw_pc_excl", 32'(reg_write & pc_en),    32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int fs, input int ms);
    op = o; funct = f; zero = z;
    mem_ready = 1'b0;
    repeat (fs) tick();
    mem_ready = 1'b1;
    if (ms > 0) begin
      repeat (3) tick();
      mem_ready = 1'b0;
      repeat (ms) tick();
      mem_ready = 1'b1;
      repeat (seq_len(o, f) - 3) tick();
    end else begin
      repeat (seq_len(o, f)) tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    chk("rst_state",   32'(state_dbg), 32'(ST_FETCH));
    chk("rst_mem_read", 32'(mem_read), 32'd1);
    chk("rst_src_b",   32'(alu_src_b), 32'd1);
    chk("rst_count",   32'(instr_count), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;

    // R-type sub, cycle by cycle
    op = 6'b000000; funct = 6'b100010; mem_ready = 1'b1;
    tick(); tick();
    chk("sub_state", 32'(state_dbg), 32'(ST_RTYPE_EX));
    chk("sub_aluctl", 32'(alu_ctl), 32'h6);
    tick();
    chk("sub_wb", 32'({reg_dst, reg_write}), 32'h3);
    tick();
    chk("sub_count", 32'(instr_count), 32'd1);

    // lw with 3 stall cycles in MEMRD: 8 cycles total
    issue(6'b100011, 6'd0, 1'b0, 0, 3);
    chk("lw_count", 32'(instr_count), 32'd2);

    // beq taken then not taken
    op = 6'b000100; zero = 1'b1; tick(); tick();
    chk("beq_t_pc", 32'({pc_en, pc_source}), 32'b101);
    tick();
    zero = 1'b0; tick(); tick();
    chk("beq_nt_pc", 32'(pc_en), 32'd0);
    tick();
    chk("beq_count", 32'(instr_count), 32'd4);

    // mixed traffic
    issue(6'b001000, 6'd0, 1'b0, 0, 0);
    issue(6'b101011, 6'd0, 1'b0, 0, 2);
    issue(6'b000010, 6'd0, 1'b0, 2, 0);
    issue(6'b000000, 6'b100000, 1'b0, 0, 0);
    issue(6'b000000, 6'b100100, 1'b0, 1, 0);
    issue(6'b000000, 6'b100101, 1'b0, 0, 0);
    issue(6'b000000, 6'b101010, 1'b0, 0, 0);
    chk("mix_count", 32'(instr_count), 32'd11);

    // illegal opcode: absorbing trap
    op = 6'b111111; tick(); tick();
    chk("trap_illegal", 32'(illegal), 32'd1);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      tick();
    end
    chk("trap_hold", 32'(state_dbg), 32'(ST_TRAP));
    chk("trap_count", 32'(instr_count), 32'd11);
    rst_n = 1'b0; tick(); rst_n = 1'b1; mem_ready = 1'b1;
    chk("trap_rst_ill", 32'(illegal), 32'd0);
    chk("trap_rst_state", 32'(state_dbg), 32'(ST_FETCH));

    // illegal funct in R-type
    op = 6'b000000; funct = 6'b100001; tick(); tick();
    chk("badfn_illegal", 32'(illegal), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // reset in the middle of a stalled store
    op = 6'b101011; mem_ready = 1'b1; tick(); tick();
    mem_ready = 1'b0; tick(); tick();
    chk("sw_hold", 32'({state_dbg, mem_write}), 32'({ST_MEMWR, 1'b1}));
    rst_n = 1'b0; tick(); rst_n = 1'b1; mem_ready = 1'b1;
    chk("midrst_state", 32'(state_dbg), 32'(ST_FETCH));
    chk("midrst_memwr", 32'(mem_write), 32'd0);
    chk("midrst_count", 32'(instr_count), 32'd0);

    // counter wrap with a 4-bit counter
    repeat (15) issue(6'b000010, 6'd0, 1'b0, 0, 0);
    chk("wrap_15", 32'(instr_count), 32'd15);
    issue(6'b000010, 6'd0, 1'b0, 0, 0);
    chk("wrap_0", 32'(instr_count), 32'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
